// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package counter_pkg;

    localparam int unsigned CNT_WRAP = 0;
    localparam int unsigned CNT_SAT  = 1;

    // Clamp a load value into the legal count range 0..modulus-1.
    function automatic int unsigned clamp_load(input int unsigned val, input int unsigned modulus);
        return (val >= modulus) ? (modulus - 1) : val;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits one tick per PRESCALE cycles of en.
module counter_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    if (PRESCALE <= 1) begin : g_direct
        // No division needed: every enabled cycle is a tick.
        logic unused_p1;
        assign unused_p1 = &{1'b0, clk, rst, sync_clr};
        assign tick      = en;
    end else begin : g_div
        localparam int unsigned PW = $clog2(PRESCALE);
        localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

        logic [PW-1:0] pcnt_q;
        logic [PW-1:0] pcnt_d;

        assign tick = en && (pcnt_q == LAST);

        // Advance modulo PRESCALE on en; restart on clear.
        always_comb begin
            pcnt_d = pcnt_q;
            if (sync_clr) begin
                pcnt_d = '0;
            end else if (en) begin
                pcnt_d = tick ? '0 : pcnt_q + PW'(1);
            end
        end

        // Prescale count register with synchronous reset.
        always_ff @(posedge clk) begin
            if (!rst) begin
                pcnt_q <= '0;
            end else begin
                pcnt_q <= pcnt_d;
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Modulo-N up/down counter with load, clear, wrap/saturate, tc pulse and sticky ovf.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned SAT_MODE = 0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < 1 || MODULUS < 2 || PRESCALE < 1 ||
        64'(MODULUS) > (64'(1) << WIDTH)) begin : g_bad_params
        $error("updown_counter_param: illegal WIDTH/MODULUS/PRESCALE combination");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam bit               SAT     = (SAT_MODE == CNT_SAT);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             tick;
    logic [WIDTH-1:0] load_clamped;

    assign load_clamped = WIDTH'(clamp_load(32'(load_val), MODULUS));

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync_clr (clr | load),
        .tick     (tick)
    );

    // Priority mux clr > load > step, with limit detection driving tc/ovf.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_clr ? 1'b0 : ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            cnt_d = load_clamped;
        end else if (tick) begin
            if (up) begin
                if (cnt_q == MAX_VAL) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    cnt_d = SAT ? cnt_q : '0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    cnt_d = SAT ? cnt_q : MAX_VAL;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    // Output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench: three counter variants share stimulus; a reference model feeds per-DUT scoreboards.
module tb_updown_counter_param;

    typedef struct packed {
        logic [3:0] q;
        logic       tc;
        logic       ovf;
    } exp_t;

    localparam int MODV = 10;

    logic       clk = 1'b0;
    logic       rst, en, up, clr, load, ovf_clr;
    logic [3:0] load_val;

    logic [3:0] q0, q1, q2;
    logic       tc0, tc1, tc2, ovf0, ovf1, ovf2;

    int errors = 0;
    int checks = 0;

    exp_t sb0[$], sb1[$], sb2[$];

    int mq[3], mp[3];
    bit mtc[3], movf[3];
    int msat[3] = '{0, 1, 0};
    int mpre[3] = '{1, 1, 3};

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SAT_MODE(0), .PRESCALE(1)) d0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(q0), .tc(tc0), .ovf(ovf0));
    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SAT_MODE(1), .PRESCALE(1)) d1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(q1), .tc(tc1), .ovf(ovf1));
    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SAT_MODE(0), .PRESCALE(3)) d2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(q2), .tc(tc2), .ovf(ovf2));

    // Reference behaviour for one counter variant given the current inputs.
    function automatic exp_t model_next(input int k);
        exp_t e;
        bit   tick;
        if (!rst) begin
            mq[k] = 0; mp[k] = 0; mtc[k] = 0; movf[k] = 0;
        end else if (clr) begin
            mq[k] = 0; mp[k] = 0; mtc[k] = 0; movf[k] = 0;
        end else if (load) begin
            mq[k]   = (int'(load_val) >= MODV) ? MODV - 1 : int'(load_val);
            mp[k]   = 0;
            mtc[k]  = 0;
            if (ovf_clr) movf[k] = 0;
        end else begin
            tick   = en && (mp[k] == mpre[k] - 1);
            if (en) mp[k] = (mp[k] + 1) % mpre[k];
            mtc[k] = 0;
            if (ovf_clr) movf[k] = 0;
            if (tick) begin
                if (up) begin
                    if (mq[k] < MODV - 1) mq[k] = mq[k] + 1;
                    else begin
                        mtc[k] = 1; movf[k] = 1;
                        if (msat[k] == 0) mq[k] = 0;
                    end
                end else begin
                    if (mq[k] > 0) mq[k] = mq[k] - 1;
                    else begin
                        mtc[k] = 1; movf[k] = 1;
                        if (msat[k] == 0) mq[k] = MODV - 1;
                    end
                end
            end
        end
        e.q   = 4'(mq[k]);
        e.tc  = mtc[k];
        e.ovf = movf[k];
        return e;
    endfunction

    // Apply current inputs for one clock, then compare all three DUTs against the scoreboard.
    task automatic step();
        exp_t e, o;
        sb0.push_back(model_next(0));
        sb1.push_back(model_next(1));
        sb2.push_back(model_next(2));
        @(posedge clk);
        #1;
        e = sb0.pop_front(); o = '{q0, tc0, ovf0}; checks++;
        if (o !== e) begin errors++; $display("FAIL sb_d0 t=%0t got q=%0d tc=%b ovf=%b want q=%0d tc=%b ovf=%b", $time, o.q, o.tc, o.ovf, e.q, e.tc, e.ovf); end
        e = sb1.pop_front(); o = '{q1, tc1, ovf1}; checks++;
        if (o !== e) begin errors++; $display("FAIL sb_d1 t=%0t got q=%0d tc=%b ovf=%b want q=%0d tc=%b ovf=%b", $time, o.q, o.tc, o.ovf, e.q, e.tc, e.ovf); end
        e = sb2.pop_front(); o = '{q2, tc2, ovf2}; checks++;
        if (o !== e) begin errors++; $display("FAIL sb_d2 t=%0t got q=%0d tc=%b ovf=%b want q=%0d tc=%b ovf=%b", $time, o.q, o.tc, o.ovf, e.q, e.tc, e.ovf); end
    endtask

    task automatic idle();
        rst = 1; en = 0; up = 1; clr = 0; load = 0; ovf_clr = 0; load_val = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 0; en = 1; load = 1; load_val = 4'd5;
        step(); step();
        checks++;
        if ({q0, tc0, ovf0} !== 6'b0) begin errors++; $display("FAIL reset_state got q=%0d tc=%b ovf=%b want 0 0 0", q0, tc0, ovf0); end
        rst = 1; load = 0; en = 1; up = 1;
        step();
        checks++;
        if (q0 !== 4'd1) begin errors++; $display("FAIL reset_release got q=%0d want 1", q0); end
        idle(); clr = 1; step();
    endtask

    task automatic test_wrap_up();
        idle(); en = 1; up = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (q0 !== 4'((i + 1) % 10) || tc0 !== (i == 9)) begin
                errors++; $display("FAIL wrap_up i=%0d got q=%0d tc=%b want q=%0d tc=%b", i, q0, tc0, (i + 1) % 10, i == 9);
            end
        end
        en = 0; step();
        checks++;
        if (ovf0 !== 1'b1 || tc0 !== 1'b0) begin errors++; $display("FAIL wrap_up_ovf got ovf=%b tc=%b want 1 0", ovf0, tc0); end
    endtask

    task automatic test_wrap_down();
        idle(); load = 1; load_val = 0; step();
        load = 0; en = 1; up = 0; step();
        checks++;
        if (q0 !== 4'd9 || tc0 !== 1'b1) begin errors++; $display("FAIL wrap_down got q=%0d tc=%b want 9 1", q0, tc0); end
        en = 0; ovf_clr = 1; step();
        checks++;
        if (ovf0 !== 1'b0 || q0 !== 4'd9) begin errors++; $display("FAIL ovf_clr got ovf=%b q=%0d want 0 9", ovf0, q0); end
        ovf_clr = 0; load = 1; load_val = 0; step();
        load = 0; en = 1; up = 0; ovf_clr = 1; step();
        checks++;
        if (ovf0 !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got ovf=%b want 1", ovf0); end
    endtask

    task automatic test_saturate();
        logic [3:0] wq[3]  = '{4'd9, 4'd9, 4'd9};
        logic       wtc[3] = '{1'b0, 1'b1, 1'b1};
        idle(); load = 1; load_val = 4'd8; step();
        load = 0; en = 1; up = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q1 !== wq[i] || tc1 !== wtc[i]) begin errors++; $display("FAIL sat_up i=%0d got q=%0d tc=%b want q=%0d tc=%b", i, q1, tc1, wq[i], wtc[i]); end
        end
        up = 0; step();
        checks++;
        if (q1 !== 4'd8 || tc1 !== 1'b0) begin errors++; $display("FAIL sat_down got q=%0d tc=%b want 8 0", q1, tc1); end
    endtask

    task automatic test_priority();
        idle(); load = 1; load_val = 4'd6; step();
        clr = 1; load = 1; en = 1; load_val = 4'd5; step();
        checks++;
        if (q0 !== 4'd0 || q1 !== 4'd0) begin errors++; $display("FAIL clr_prio got q0=%0d q1=%0d want 0 0", q0, q1); end
        clr = 0; en = 0; load_val = 4'd13; step();
        checks++;
        if (q0 !== 4'd9 || q1 !== 4'd9) begin errors++; $display("FAIL load_clamp got q0=%0d q1=%0d want 9 9", q0, q1); end
        en = 1; load_val = 4'd4; step();
        checks++;
        if (q0 !== 4'd4) begin errors++; $display("FAIL load_over_en got q=%0d want 4", q0); end
    endtask

    task automatic test_prescale();
        logic [3:0] wdel[4] = '{4'd0, 4'd0, 4'd0, 4'd1};
        logic       edel[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        idle(); clr = 1; step();
        clr = 0; en = 1; up = 1;
        for (int i = 1; i <= 9; i++) begin
            step();
            checks++;
            if (q2 !== 4'(i / 3)) begin errors++; $display("FAIL prescale_run i=%0d got q=%0d want %0d", i, q2, i / 3); end
        end
        idle(); clr = 1; step(); clr = 0; up = 1;
        for (int i = 0; i < 4; i++) begin
            en = edel[i]; step();
            checks++;
            if (q2 !== wdel[i]) begin errors++; $display("FAIL prescale_gap i=%0d got q=%0d want %0d", i, q2, wdel[i]); end
        end
        en = 1; step(); step();
        rst = 0; step();
        rst = 1; en = 1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (q2 !== 4'(i / 3)) begin errors++; $display("FAIL prescale_rst i=%0d got q=%0d want %0d", i, q2, i / 3); end
        end
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 0; i < 300; i++) begin
            rst      = ($urandom_range(0, 59) != 0);
            clr      = ($urandom_range(0, 24) == 0);
            load     = ($urandom_range(0, 11) == 0);
            ovf_clr  = ($urandom_range(0, 7) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up       = ($urandom_range(0, 3) != 0) ^ (i >= 150);
            load_val = 4'($urandom_range(0, 15));
            step();
        end
    endtask

    initial begin
        idle();
        rst = 0;
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_priority();
        test_prescale();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
